// File: rtl/axi_rd_rr_scheduler.sv
// axi_rd_rr_scheduler: round-robin read-channel scheduler for masters M0..M2.
// Grants one master per AXI read burst, decodes its captured ARADDR to a one-hot
// slave select, and holds the grant until the RLAST handshake.
// Optional feature macro: RD_SCHED_TIMEOUT_EN (forced release after TIMEOUT_CYC
// cycles of grant, with a one-cycle timeout_o pulse).
module axi_rd_rr_scheduler #(
    parameter int ADDR_W      = 32,
    parameter int M0_PRIORITY = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [2:0]        ARVALID_M,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [ADDR_W-1:0] ARADDR_M2,
    input  logic              ARREADY_G,
    input  logic              RVALID_G,
    input  logic              RREADY_G,
    input  logic              RLAST_G,
    input  logic              AW_busy,
    output logic [2:0]        grant_o,
    output logic [7:0]        slave_sel_o,
    output logic              busy_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [1:0]        gnt_idx;
    logic [ADDR_W-1:0] addr_q;

    logic [2:0]        elig;
    logic [1:0]        win;
    logic              win_vld;
    logic [ADDR_W-1:0] win_addr;
    logic              rel_done;
    logic              rel_to;
    logic              rel;

    // addr_q is kept for observability; the select itself is registered at capture
    logic unused_addr;
    assign unused_addr = ^addr_q;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Upper 16 address bits to one-hot slave; unmapped space gives 0 (DECERR)
    function automatic logic [7:0] decode(input logic [15:0] h);
        logic [7:0] s;
        s = 8'h00;
        if (h[15:8] == 8'h20) begin
            s = 8'h20;
        end else begin
            case (h)
                16'h0000: s = 8'h01;
                16'h0001: s = 8'h02;
                16'h0002: s = 8'h04;
                16'h0003: s = 8'h80;
                16'h0010: s = 8'h40;
                16'h1000: s = 8'h08;
                16'h1001: s = 8'h10;
                default:  s = 8'h00;
            endcase
        end
        return s;
    endfunction

    // Winner: first eligible master scanning upward from rr_ptr (mod 3); M0 may override
    always_comb begin
        logic [1:0] o0, o1, o2;
        elig    = ARVALID_M & ~{AW_busy, AW_busy, 1'b0};
        win_vld = |elig;
        o0      = rr_ptr;
        o1      = inc3(o0);
        o2      = inc3(o1);
        win     = o0;
        if (elig[o2]) win = o2;
        if (elig[o1]) win = o1;
        if (elig[o0]) win = o0;
        if (M0_PRIORITY != 0 && elig[0]) win = 2'd0;
    end

    // Address of the prospective winner
    always_comb begin
        case (win)
            2'd0:    win_addr = ARADDR_M0;
            2'd1:    win_addr = ARADDR_M1;
            default: win_addr = ARADDR_M2;
        endcase
    end

    assign rel_done = (state == DATA) && RVALID_G && RREADY_G && RLAST_G;

`ifdef RD_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    // Counter hits TIMEOUT_CYC on this edge; a completing burst takes precedence
    assign rel_to = (state != IDLE) && !rel_done && (cnt == CW'(TIMEOUT_CYC - 1));

    // Grant-age counter: cleared on grant, counts while a transaction is open
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= rel_to;
            if (state == IDLE) cnt <= '0;
            else if (!rel)     cnt <= cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign rel_to    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign rel = rel_done | rel_to;

    // Scheduler FSM with registered grant/select/busy outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            gnt_idx     <= 2'd0;
            addr_q      <= '0;
            grant_o     <= 3'b000;
            slave_sel_o <= 8'h00;
            busy_o      <= 1'b0;
        end else if (rel) begin
            // Release; the next grant can only be issued from IDLE next cycle
            state       <= IDLE;
            rr_ptr      <= inc3(gnt_idx);
            grant_o     <= 3'b000;
            slave_sel_o <= 8'h00;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state       <= ADDR;
                        gnt_idx     <= win;
                        grant_o     <= 3'b001 << win;
                        addr_q      <= win_addr;
                        slave_sel_o <= decode(win_addr[ADDR_W-1 -: 16]);
                        busy_o      <= 1'b1;
                    end
                end
                ADDR: begin
                    if (ARREADY_G) state <= DATA;
                end
                DATA: begin
                    // Non-last beats keep the grant; last beat handled by rel
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
